// File: rtl/eth_xfer_sched.sv
// eth_xfer_sched: two-requester round-robin scheduler issuing one eth_task transfer at a time
// Ports: mclk/reset (sync, active-high); reqN/ram_selN/addrN/sizeN request descriptors;
//   gntN grant pulse, doneN/errN completion pulse; eth_start/eth_ram_sel/eth_addr/eth_size
//   drive eth_task, eth_done returns from it; busy is high outside IDLE.
// Macro ETH_XFER_SCHED_WDT_EN adds the WAIT watchdog (TIMEOUT_CYC cycles, TMO_W-bit counter).
module eth_xfer_sched #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TMO_W = 20
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        ram_sel0,
  input  logic        ram_sel1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [12:0] size0,
  input  logic [12:0] size1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        eth_start,
  output logic        eth_ram_sel,
  output logic [23:0] eth_addr,
  output logic [12:0] eth_size,
  input  logic        eth_done,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
  state_t r_state, w_next;
  logic r_last, r_owner, r_ram_sel, r_err;
  logic [23:0] r_addr;
  logic [12:0] r_size;
  logic w_win, w_tmo;
  if (TIMEOUT_CYC < 2 || TMO_W < $clog2(TIMEOUT_CYC)) begin : g_bad_wdt_cfg
  end
  // Requester 1 wins alone or on a tie when requester 0 was served last.
  assign w_win = (req0 && req1) ? ~r_last : req1;
`ifdef ETH_XFER_SCHED_WDT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  always_ff @(posedge mclk)
    r_tmo_cnt <= (reset || r_state != S_WAIT) ? '0 : r_tmo_cnt + 1'b1;
  assign w_tmo = (r_state == S_WAIT) && (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = (req0 || req1) ? S_START : S_IDLE;
      S_START: w_next = (r_size == '0) ? S_DONE : S_WAIT;
      S_WAIT:  w_next = (eth_done || w_tmo) ? S_DONE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_ram_sel <= 1'b0;
      r_addr    <= '0;
      r_size    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_START) begin
        r_owner   <= w_win;
        r_ram_sel <= w_win ? ram_sel1 : ram_sel0;
        r_addr    <= w_win ? addr1 : addr0;
        r_size    <= w_win ? size1 : size0;
      end
      // Entering DONE from WAIT without eth_done can only be the watchdog; eth_done wins a tie.
      if (r_state != S_DONE && w_next == S_DONE) begin
        r_last <= r_owner;
        r_err  <= (r_state == S_START) || !eth_done;
      end
    end
  end
  assign gnt0        = (r_state == S_START) && !r_owner;
  assign gnt1        = (r_state == S_START) && r_owner;
  assign done0       = (r_state == S_DONE) && !r_owner;
  assign done1       = (r_state == S_DONE) && r_owner;
  assign err0        = done0 && r_err;
  assign err1        = done1 && r_err;
  assign eth_start   = (r_state == S_START) && (r_size != '0);
  assign eth_ram_sel = r_ram_sel;
  assign eth_addr    = r_addr;
  assign eth_size    = r_size;
  assign busy        = r_state != S_IDLE;
endmodule
